// File: rtl/xcom_pkg.sv
// Shared types and helpers for the XCOM transmit command path.
package xcom_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWsync = 2'd1,
    StSend  = 2'd2,
    StFlush = 2'd3
  } txq_st_e;

  localparam logic [3:0] XcmdSync = 4'b1000;

  function automatic logic is_sync(logic [7:0] hd);
    return hd[7:4] == XcmdSync;
  endfunction

endpackage

// File: rtl/sync_reg.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync_reg #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] s1_q, s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/xcom_cmd_fifo.sv
// Synchronous FIFO of 2**Aw entries; head is read combinationally from storage.
module xcom_cmd_fifo #(
  parameter int unsigned Width = 40,
  parameter int unsigned Aw    = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clr_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Aw:0]      count_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned Depth = 2 ** Aw;

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
  logic [Aw:0]      cnt_q;
  logic             do_push, do_pop;

  // Count never exceeds Depth, so its MSB alone marks full.
  assign full_o  = cnt_q[Aw];
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o & ~clr_i;
  assign do_pop  = pop_i & ~empty_o & ~clr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + Aw'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + Aw'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (Aw+1)'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - (Aw+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/xcom_tx_cmdq.sv
// Queued XCOM TX controller: buffers commands, holds sync commands for a
// synchronised pulse edge (or drops them on timeout), then hands them to the link.
module xcom_tx_cmdq
  import xcom_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned QD = 3,
  parameter int unsigned TW = 16
) (
  input  logic          x_clk_i,
  input  logic          x_rst_ni,
  input  logic          pulse_sync_i,
  input  logic [TW-1:0] tmo_cfg_i,
  input  logic          flush_i,
  input  logic          cmd_req_i,
  output logic          cmd_rdy_o,
  input  logic [7:0]    cmd_hd_i,
  input  logic [DW-1:0] cmd_dt_i,
  output logic          link_vld_o,
  input  logic          link_rdy_i,
  output logic [7:0]    link_hd_o,
  output logic [DW-1:0] link_dt_o,
  output logic [QD:0]   q_cnt_o,
  output logic [7:0]    tmo_cnt_o,
  output logic          sync_tmo_o,
  output logic [1:0]    st_do
);

  txq_st_e         state_q, state_d;
  logic            rdy_en_q, flush_pend_q;
  logic [TW-1:0]   tmo_q;
  logic [7:0]      tmo_cnt_q;
  logic            sync_tmo_q;
  logic            sync_s, sync_prev_q, sync_ev_q;
  logic            full, empty, push, pop, clr, tmo_clr, drop;
  logic [QD:0]     count;
  logic [DW+7:0]   head;

  sync_reg #(.Width(1)) u_sync (
    .clk_i  (x_clk_i),
    .rst_ni (x_rst_ni),
    .d_i    (pulse_sync_i),
    .q_o    (sync_s)
  );

  xcom_cmd_fifo #(.Width(DW + 8), .Aw(QD)) u_fifo (
    .clk_i   (x_clk_i),
    .rst_ni  (x_rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .clr_i   (clr),
    .data_i  ({cmd_hd_i, cmd_dt_i}),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .head_o  (head)
  );

  // rdy_en_q keeps cmd_rdy_o low while reset is asserted.
  assign cmd_rdy_o = rdy_en_q & ~full & ~flush_pend_q;
  assign push      = cmd_req_i & cmd_rdy_o;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    clr     = 1'b0;
    tmo_clr = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush_pend_q) begin
          state_d = StFlush;
        end else if (!empty) begin
          if (is_sync(head[DW+7:DW])) begin
            state_d = StWsync;
            tmo_clr = 1'b1;
          end else begin
            state_d = StSend;
          end
        end
      end
      StWsync: begin
        if (flush_pend_q) begin
          state_d = StFlush;
        end else if (sync_ev_q) begin
          state_d = StSend;
        end else if (tmo_cfg_i != '0 && tmo_q == tmo_cfg_i - TW'(1)) begin
          pop     = 1'b1;
          drop    = 1'b1;
          state_d = StIdle;
        end
      end
      StSend: begin
        if (link_rdy_i) begin
          pop     = 1'b1;
          state_d = StIdle;
        end
      end
      StFlush: begin
        clr     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge x_clk_i or negedge x_rst_ni) begin
    if (!x_rst_ni) begin
      state_q      <= StIdle;
      rdy_en_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      tmo_q        <= '0;
      tmo_cnt_q    <= '0;
      sync_tmo_q   <= 1'b0;
      sync_prev_q  <= 1'b0;
      sync_ev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdy_en_q     <= 1'b1;
      flush_pend_q <= (flush_pend_q & (state_q != StFlush)) | flush_i;
      sync_prev_q  <= sync_s;
      sync_ev_q    <= sync_s & ~sync_prev_q;
      sync_tmo_q   <= drop;
      if (tmo_clr)                  tmo_q <= '0;
      else if (state_q == StWsync)  tmo_q <= tmo_q + TW'(1);
      if (drop && tmo_cnt_q != 8'hff) tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end

  assign link_vld_o = (state_q == StSend);
  assign link_hd_o  = link_vld_o ? head[DW+7:DW] : 8'h00;
  assign link_dt_o  = link_vld_o ? head[DW-1:0] : '0;
  assign q_cnt_o    = count;
  assign tmo_cnt_o  = tmo_cnt_q;
  assign sync_tmo_o = sync_tmo_q;
  assign st_do      = state_q;

endmodule

// File: tb/tb_xcom_tx_cmdq.sv
// Directed/randomised bench for xcom_tx_cmdq with a queue-based reference model.
module tb_xcom_tx_cmdq;

  logic        clk = 1'b0;
  logic        rst_n, pulse, flush, req, link_rdy;
  logic [15:0] tmo_cfg;
  logic [7:0]  cmd_hd;
  logic [31:0] cmd_dt;
  logic        cmd_rdy_o, link_vld_o, sync_tmo_o;
  logic [7:0]  link_hd_o, tmo_cnt_o;
  logic [31:0] link_dt_o;
  logic [3:0]  q_cnt_o;
  logic [1:0]  st_do;

  int n_chk = 0, n_fail = 0, n_xfer = 0;
  logic [39:0] mq[$];
  logic        m_fp = 1'b0;
  logic        prev_xfer = 1'b0, prev_stall = 1'b0;
  logic [39:0] prev_ent = '0;

  xcom_tx_cmdq dut (
    .x_clk_i      (clk),
    .x_rst_ni     (rst_n),
    .pulse_sync_i (pulse),
    .tmo_cfg_i    (tmo_cfg),
    .flush_i      (flush),
    .cmd_req_i    (req),
    .cmd_rdy_o    (cmd_rdy_o),
    .cmd_hd_i     (cmd_hd),
    .cmd_dt_i     (cmd_dt),
    .link_vld_o   (link_vld_o),
    .link_rdy_i   (link_rdy),
    .link_hd_o    (link_hd_o),
    .link_dt_o    (link_dt_o),
    .q_cnt_o      (q_cnt_o),
    .tmo_cnt_o    (tmo_cnt_o),
    .sync_tmo_o   (sync_tmo_o),
    .st_do        (st_do)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rand_ns_hd();
    logic [7:0] h;
    h = 8'($urandom);
    if (h[7:4] == 4'h8) h[7] = 1'b0;
    return h;
  endfunction

  // One clock: sample mid-cycle, score link transfers and pushes, then step past the edge.
  task automatic tick();
    logic        exp_rdy;
    logic [39:0] e;
    @(negedge clk);
    exp_rdy = (mq.size() < 8) && !m_fp;
    if (prev_xfer) check("vld_gap", 64'(link_vld_o), 64'd0);
    if (prev_stall && link_vld_o) check("stall_stable", {link_hd_o, link_dt_o}, prev_ent);
    if (!link_vld_o) check("idle_zero", {link_hd_o, link_dt_o}, 64'd0);
    if (link_vld_o && link_rdy) begin
      n_chk++;
      assert (mq.size() > 0) else begin
        n_fail++;
        $error("FAIL xfer_unexpected: observed hd %0h dt %0h expected no transfer",
               link_hd_o, link_dt_o);
      end
      if (mq.size() > 0) begin
        e = mq.pop_front();
        check("link_cmd", {link_hd_o, link_dt_o}, e);
      end
      n_xfer++;
    end
    if (req) begin
      check("cmd_rdy", 64'(cmd_rdy_o), 64'(exp_rdy));
      if (exp_rdy) mq.push_back({cmd_hd, cmd_dt});
    end
    prev_xfer  = link_vld_o && link_rdy;
    prev_stall = link_vld_o && !link_rdy;
    prev_ent   = {link_hd_o, link_dt_o};
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [7:0] h, logic [31:0] d);
    req = 1'b1; cmd_hd = h; cmd_dt = d;
    tick();
    req = 1'b0;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_vld", 64'(link_vld_o), 64'd0);
    check("rst_out", {link_hd_o, link_dt_o, q_cnt_o, tmo_cnt_o, sync_tmo_o, st_do, cmd_rdy_o},
          64'd0);
    mq.delete();
    m_fp = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(2);
    check("post_rst_st", 64'(st_do), 64'd0);
    check("post_rst_cnt", 64'(q_cnt_o), 64'd0);
    check("post_rst_rdy", 64'(cmd_rdy_o), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; pulse = 1'b0; flush = 1'b0; req = 1'b0; link_rdy = 1'b0;
    tmo_cfg = '0; cmd_hd = '0; cmd_dt = '0;
    #12;
    do_reset();

    // Three non-sync commands, stalled then drained.
    push(8'h10, 32'hA0);
    tick();
    check("lat_st", 64'(st_do), 64'd2);
    check("lat_vld", 64'(link_vld_o), 64'd1);
    push(8'h11, 32'hA1);
    push(8'h12, 32'hA2);
    check("q3", 64'(q_cnt_o), 64'd3);
    link_rdy = 1'b1;
    ticks(8);
    check("q3_drain", 64'(q_cnt_o), 64'd0);
    check("xfer3", 64'(n_xfer), 64'd3);

    // Fill to 8, overflow attempt, drain.
    link_rdy = 1'b0;
    for (int i = 0; i < 9; i++) push(rand_ns_hd(), $urandom);
    check("full_cnt", 64'(q_cnt_o), 64'd8);
    check("full_rdy", 64'(cmd_rdy_o), 64'd0);
    link_rdy = 1'b1;
    tick();
    check("pop1_rdy", 64'(cmd_rdy_o), 64'd1);
    check("pop1_cnt", 64'(q_cnt_o), 64'd7);
    ticks(20);
    check("full_drain", 64'(q_cnt_o), 64'd0);
    check("xfer11", 64'(n_xfer), 64'd11);

    // Sync command released by pulse, no timeout.
    push(8'h83, $urandom);
    tick();
    check("wsync_st", 64'(st_do), 64'd1);
    ticks(50);
    check("wsync_hold", 64'(st_do), 64'd1);
    pulse = 1'b1;
    tick();
    tick();
    tick();
    check("sync_lat2", 64'(link_vld_o), 64'd0);
    tick();
    check("sync_lat3", 64'(link_vld_o), 64'd1);
    ticks(3);
    pulse = 1'b0;
    ticks(6);
    check("xfer12", 64'(n_xfer), 64'd12);

    // Sync timeout drop, then a following non-sync command.
    tmo_cfg = 16'd10;
    push({4'h8, 4'($urandom)}, $urandom);
    push(rand_ns_hd(), $urandom);
    check("tmo_wsync", 64'(st_do), 64'd1);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("tmo_early", 64'(sync_tmo_o), 64'd0);
    end
    tick();
    check("tmo_pulse", 64'(sync_tmo_o), 64'd1);
    check("tmo_cnt", 64'(tmo_cnt_o), 64'd1);
    void'(mq.pop_front());
    tick();
    check("tmo_pulse_end", 64'(sync_tmo_o), 64'd0);
    ticks(4);
    check("xfer13", 64'(n_xfer), 64'd13);
    check("tmo_q0", 64'(q_cnt_o), 64'd0);

    // Sync edge lands on the last wait cycle: sync wins.
    push({4'h8, 4'($urandom)}, $urandom);
    ticks(7);
    pulse = 1'b1;
    ticks(3);
    check("race_wsync", 64'(st_do), 64'd1);
    tick();
    check("race_send", 64'(st_do), 64'd2);
    check("race_nodrop", {tmo_cnt_o, 7'd0, sync_tmo_o}, {8'd1, 8'd0});
    ticks(4);
    pulse = 1'b0;
    check("xfer14", 64'(n_xfer), 64'd14);

    // Flush requested while stalled in SEND.
    link_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push(rand_ns_hd(), $urandom);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    m_fp  = 1'b1;
    push(rand_ns_hd(), $urandom);
    check("fl_send", 64'(st_do), 64'd2);
    check("fl_cnt4", 64'(q_cnt_o), 64'd4);
    link_rdy = 1'b1;
    tick();
    check("fl_idle", 64'(st_do), 64'd0);
    check("fl_cnt3", 64'(q_cnt_o), 64'd3);
    tick();
    check("fl_state", 64'(st_do), 64'd3);
    tick();
    check("fl_done", 64'(st_do), 64'd0);
    check("fl_cnt0", 64'(q_cnt_o), 64'd0);
    check("fl_rdy", 64'(cmd_rdy_o), 64'd1);
    mq.delete();
    m_fp = 1'b0;
    check("xfer15", 64'(n_xfer), 64'd15);

    // Reset while waiting for sync, then while presenting to the link.
    tmo_cfg = '0;
    push(8'h8C, $urandom);
    tick();
    check("rw_wsync", 64'(st_do), 64'd1);
    do_reset();
    link_rdy = 1'b0;
    push(rand_ns_hd(), $urandom);
    tick();
    check("rs_vld", 64'(link_vld_o), 64'd1);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xcom_tx_cmdq.md
Name: xcom_tx_cmdq

Overview:
Queued, parametrised successor to the single-command XCOM TX controller. It accepts header+data commands into a FIFO of depth 2**QD. It holds sync-class commands until a synchronised pulse_sync edge arrives, or drops them on a programmable timeout. It then presents each command to the link serializer over a valid/ready handshake. It sits between the core command interface and the XCOM link transmitter.

Parameters:
DW, 32, command data width.
QD, 3, log2 of queue depth; depth = 2**QD = 8.
TW, 16, width of the sync-timeout counter and its config.

Ports:
x_clk_i  in  1  XCOM clock.
x_rst_ni  in  1  reset, asynchronous, active-low.
pulse_sync_i  in  1  asynchronous sync pulse.
tmo_cfg_i  in  TW  sync-wait timeout in cycles; 0 disables the timeout.
flush_i  in  1  request to clear the queue.
cmd_req_i  in  1  command valid.
cmd_rdy_o  out  1  queue can accept a command.
cmd_hd_i  in  8  command header; [7:4]==4'b1000 marks a sync command.
cmd_dt_i  in  DW  command data.
link_vld_o  out  1  command valid toward the serializer.
link_rdy_i  in  1  serializer accepts the command.
link_hd_o  out  8  header of the head command.
link_dt_o  out  DW  data of the head command.
q_cnt_o  out  QD+1  queue occupancy.
tmo_cnt_o  out  8  saturating count of sync commands dropped by timeout.
sync_tmo_o  out  1  one-cycle pulse when a command is dropped.
st_do  out  2  debug state: 0 IDLE, 1 WSYNC, 2 SEND, 3 FLUSH.

Behaviour:
- Reset (async assert, sync release): queue empty, state IDLE. All outputs 0 except cmd_rdy_o, which is also 0 during reset. Reset mid-operation discards every entry and drops link_vld_o immediately.
- Push: occurs on a clock edge where cmd_req_i and cmd_rdy_o are both 1.
  - cmd_rdy_o = !full & !flush_pend.
  - When full, cmd_req_i is ignored. No overwrite, no error.
- Push and pop on the same edge: q_cnt_o is unchanged. Pointers wrap modulo 2**QD.
- Sync path: pulse_sync_i passes through a 2-flop synchroniser into a registered edge detector.
  - sync_ev is high for one cycle per rising edge.
  - sync_ev is honoured only in WSYNC. Edges in any other state are discarded, not stored.
- FSM (registered; evaluated in priority order within each state):
  - IDLE:
    - flush_pend -> FLUSH.
    - Else, queue non-empty and head header[7:4]==1000 -> WSYNC; tmo counter cleared.
    - Else, queue non-empty -> SEND.
  - WSYNC:
    - flush_pend -> FLUSH; the head command is discarded with the rest of the queue.
    - Else sync_ev -> SEND.
    - Else tmo_cfg_i!=0 and counter==tmo_cfg_i-1 -> pop head, pulse sync_tmo_o, increment tmo_cnt_o (saturating at 255), go to IDLE.
    - If sync_ev and timeout coincide, sync wins.
    - The counter increments each WSYNC cycle.
  - SEND:
    - link_vld_o=1; link_hd_o/link_dt_o show the head entry and stay stable while vld=1 and rdy=0.
    - On link_rdy_i: pop and go to IDLE; vld drops for at least one cycle between commands.
    - Flush never interrupts SEND; it stays pending.
  - FLUSH: one cycle; clears pointers, count and flush_pend; then goes to IDLE.
- flush_i is sampled into flush_pend (sticky until FLUSH executes). Any push accepted on the same edge flush_i is sampled is kept, then flushed.
- Latency:
  - Non-sync command accepted at edge 0 into an empty queue, in IDLE: state SEND and link_vld_o=1 after edge 1.
  - Sync command: link_vld_o=1 three edges after the first edge that samples pulse_sync_i high.
- link_hd_o/link_dt_o are 0 whenever link_vld_o=0.

Decomposition:
- Shared package xcom_pkg:
  - TYPE_TXQ_ST enum (IDLE, WSYNC, SEND, FLUSH; sequential encoding).
  - Constant XCMD_SYNC = 4'b1000.
  - Function is_sync(hd).
- Sub-module xcom_cmd_fifo:
  - Parametrised synchronous FIFO, width 8+DW, depth 2**QD.
  - Ports: push, pop, clr, full, empty, count, head data.
  - Head is available combinationally from registered storage.
- Existing sync_reg is reused for the pulse synchroniser.

Test Plan:
- Push 3 non-sync commands (hd 0x10/0x11/0x12, dt 0xA0..A2), link_rdy_i=1 -> three link transfers in order. Each link_vld_o is high one cycle, separated by one idle cycle. q_cnt_o goes 3->0.
- Fill 8 entries with link_rdy_i=0 -> cmd_rdy_o=0 and q_cnt_o=8. A 9th request is ignored. Raising rdy drains all 8 in order; cmd_rdy_o returns to 1 after the first pop.
- Sync command hd 0x83, tmo_cfg_i=0; pulse_sync_i rises after 50 cycles -> st_do=1 for the wait, link_vld_o rises 3 edges after the pulse is sampled, link_dt_o correct.
- Sync command, tmo_cfg_i=10, no pulse -> sync_tmo_o pulses after 10 WSYNC cycles, tmo_cnt_o=1, and the following non-sync command is sent. Sync edge on the 10th cycle -> command sent, no drop.
- Stall in SEND with link_rdy_i=0 and assert flush_i with 4 entries queued -> current command completes when rdy=1, then FLUSH, q_cnt_o=0. cmd_rdy_o=0 while the flush is pending.
- Assert x_rst_ni low while in WSYNC and while in SEND with vld high -> outputs 0 immediately. After release: state IDLE, q_cnt_o=0, cmd_rdy_o=1.
